id_ex_stage: RTL

- ID/EX pipeline stage sitting directly downstream of the register file in the pipelined processor.
- Captures decoded operands (readdata1/readdata2 from the register file), immediate, destination and control bundle, and presents them to EX.
- Handles valid/ready flow control, flush, and load-use hazard bubble insertion.
- Handles same-cycle writeback bypass, because register file writes land on the clock edge.

---
 rtl/id_ex_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, and load-use bubble insertion.
// Define WB_BYPASS_EN to forward same-cycle register file writes into the captured/held operands.
module id_ex_stage #(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int CTRL_W      = 8,
  parameter int MEMREAD_BIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_readreg1,
  input  logic [REG_AW-1:0] id_readreg2,
  input  logic [XLEN-1:0]   id_readdata1,
  input  logic [XLEN-1:0]   id_readdata2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_RegWrite,
  input  logic [REG_AW-1:0] wb_writereg,
  input  logic [XLEN-1:0]   wb_writedata,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_data1,
  output logic [XLEN-1:0]   ex_data2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              load_use_stall
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            r_state;
  logic [REG_AW-1:0] r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0]   r_data1, r_data2, r_imm;
  logic [CTRL_W-1:0] r_ctrl;

  logic            w_hazard;
  logic            w_capture;
  logic [XLEN-1:0] w_cap_data1, w_cap_data2;
  logic [XLEN-1:0] w_hold_data1, w_hold_data2;

  // A load in EX whose destination feeds the decoding instruction must wait one cycle.
  assign w_hazard = id_valid && (r_state == FULL) && r_ctrl[MEMREAD_BIT] &&
                    (r_rd != '0) && ((r_rd == id_readreg1) || (r_rd == id_readreg2));

  assign load_use_stall = w_hazard;
  assign id_ready       = !w_hazard && ((r_state == EMPTY) || ex_ready);
  assign w_capture      = id_valid && id_ready && !flush;

`ifdef WB_BYPASS_EN
  logic w_wb_hit;

  // Register 0 is hard-wired to zero, so a write to it must never be forwarded.
  assign w_wb_hit     = wb_RegWrite && (wb_writereg != '0);
  assign w_cap_data1  = (w_wb_hit && (wb_writereg == id_readreg1)) ? wb_writedata : id_readdata1;
  assign w_cap_data2  = (w_wb_hit && (wb_writereg == id_readreg2)) ? wb_writedata : id_readdata2;
  assign w_hold_data1 = (w_wb_hit && (wb_writereg == r_rs1))       ? wb_writedata : r_data1;
  assign w_hold_data2 = (w_wb_hit && (wb_writereg == r_rs2))       ? wb_writedata : r_data2;
`else
  logic w_unused_wb;

  assign w_unused_wb  = ^{wb_RegWrite, wb_writereg, wb_writedata};
  assign w_cap_data1  = id_readdata1;
  assign w_cap_data2  = id_readdata2;
  assign w_hold_data1 = r_data1;
  assign w_hold_data2 = r_data2;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
      r_imm   <= '0;
      r_ctrl  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else if (w_capture) begin
      r_state <= FULL;
      r_rs1   <= id_readreg1;
      r_rs2   <= id_readreg2;
      r_rd    <= id_rd;
      r_data1 <= w_cap_data1;
      r_data2 <= w_cap_data2;
      r_imm   <= id_imm;
      r_ctrl  <= id_ctrl;
    end else if (r_state == FULL) begin
      if (ex_ready) begin
        r_state <= EMPTY;
      end else begin
        // Holding: only operands may change, so a late writeback is not lost.
        r_data1 <= w_hold_data1;
        r_data2 <= w_hold_data2;
      end
    end
  end

  assign ex_valid = (r_state == FULL);
  assign ex_rs1   = r_rs1;
  assign ex_rs2   = r_rs2;
  assign ex_rd    = r_rd;
  assign ex_data1 = r_data1;
  assign ex_data2 = r_data2;
  assign ex_imm   = r_imm;
  assign ex_ctrl  = r_ctrl;

endmodule
